kbd_ctl: RTL and testbench



---
 rtl/kbd_pkg.sv | 24 ++
 rtl/kbd_at2xt.sv | 37 +++
 rtl/kbd_ctl.sv | 117 +++++++++++
 tb/tb_kbd_ctl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard controller: port addresses,
// AT break prefix, status register layout and prefix FSM states.
package kbd_pkg;

  localparam logic [15:0] KBD_DATA_PORT = 16'h0060;
  localparam logic [15:0] KBD_STAT_PORT = 16'h0064;
  localparam logic [7:0]  AT_BREAK      = 8'hF0;

  localparam int STAT_OBF = 0;
  localparam int STAT_OVF = 1;
  localparam int STAT_IEN = 2;

  typedef enum logic {IDLE, BREAK} kbd_state_t;

  function automatic logic [7:0] stat_byte(input logic ien, input logic ovf, input logic obf);
    logic [7:0] s;
    s = '0;
    s[STAT_OBF] = obf;
    s[STAT_OVF] = ovf;
    s[STAT_IEN] = ien;
    return s;
  endfunction

endpackage

// File: rtl/kbd_at2xt.sv
// Combinational AT scan-code set 2 to XT set 1 translation.
// Codes outside the table (including E0/E1/F0) pass through unchanged.
module kbd_at2xt (
  input  logic [7:0] ps2_data,
  output logic [7:0] xt
);

  always_comb begin
    xt = ps2_data;
    case (ps2_data)
      8'h01: xt = 8'h43;  8'h03: xt = 8'h3F;  8'h04: xt = 8'h3D;  8'h05: xt = 8'h3B;
      8'h06: xt = 8'h3C;  8'h07: xt = 8'h58;  8'h09: xt = 8'h44;  8'h0A: xt = 8'h42;
      8'h0B: xt = 8'h40;  8'h0C: xt = 8'h3E;  8'h0D: xt = 8'h0F;  8'h0E: xt = 8'h29;
      8'h11: xt = 8'h38;  8'h12: xt = 8'h2A;  8'h14: xt = 8'h1D;  8'h15: xt = 8'h10;
      8'h16: xt = 8'h02;  8'h1A: xt = 8'h2C;  8'h1B: xt = 8'h1F;  8'h1C: xt = 8'h1E;
      8'h1D: xt = 8'h11;  8'h1E: xt = 8'h03;  8'h21: xt = 8'h2E;  8'h22: xt = 8'h2D;
      8'h23: xt = 8'h20;  8'h24: xt = 8'h12;  8'h25: xt = 8'h05;  8'h26: xt = 8'h04;
      8'h29: xt = 8'h39;  8'h2A: xt = 8'h2F;  8'h2B: xt = 8'h21;  8'h2C: xt = 8'h14;
      8'h2D: xt = 8'h13;  8'h2E: xt = 8'h06;  8'h31: xt = 8'h31;  8'h32: xt = 8'h30;
      8'h33: xt = 8'h23;  8'h34: xt = 8'h22;  8'h35: xt = 8'h15;  8'h36: xt = 8'h07;
      8'h3A: xt = 8'h32;  8'h3B: xt = 8'h24;  8'h3C: xt = 8'h16;  8'h3D: xt = 8'h08;
      8'h3E: xt = 8'h09;  8'h41: xt = 8'h33;  8'h42: xt = 8'h25;  8'h43: xt = 8'h17;
      8'h44: xt = 8'h18;  8'h45: xt = 8'h0B;  8'h46: xt = 8'h0A;  8'h49: xt = 8'h34;
      8'h4A: xt = 8'h35;  8'h4B: xt = 8'h26;  8'h4C: xt = 8'h27;  8'h4D: xt = 8'h19;
      8'h4E: xt = 8'h0C;  8'h52: xt = 8'h28;  8'h54: xt = 8'h1A;  8'h55: xt = 8'h0D;
      8'h58: xt = 8'h3A;  8'h59: xt = 8'h36;  8'h5A: xt = 8'h1C;  8'h5B: xt = 8'h1B;
      8'h5D: xt = 8'h2B;  8'h66: xt = 8'h0E;  8'h69: xt = 8'h4F;  8'h6B: xt = 8'h4B;
      8'h6C: xt = 8'h47;  8'h70: xt = 8'h52;  8'h71: xt = 8'h53;  8'h72: xt = 8'h50;
      8'h73: xt = 8'h4C;  8'h74: xt = 8'h4D;  8'h75: xt = 8'h48;  8'h76: xt = 8'h01;
      8'h77: xt = 8'h45;  8'h78: xt = 8'h57;  8'h79: xt = 8'h4E;  8'h7A: xt = 8'h51;
      8'h7B: xt = 8'h4A;  8'h7C: xt = 8'h37;  8'h7D: xt = 8'h49;  8'h7E: xt = 8'h46;
      8'h83: xt = 8'h41;
      default: xt = ps2_data;
    endcase
  end

endmodule

// File: rtl/kbd_ctl.sv
// Keyboard controller: break-prefix FSM, set-2 to set-1 translation, byte FIFO,
// output latch at port 60h and status/command register at 64h with level IRQ.
module kbd_ctl
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_hit,
  input  logic        port_clk,
  input  logic [15:0] port,
  input  logic        port_w,
  input  logic [7:0]  port_o,
  output logic [7:0]  port_i,
  output logic        kbd_irq,
  output logic        kbd_ovf
);

  kbd_state_t  state;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [7:0]  latch;
  logic        obf, irq_en, ovf;

  logic [7:0]  xt, push_val;
  logic        empty, full, load;
  logic        push_req, push_ok, drop;
  logic        rd_data, rd_stat, wr_stat, flush;
  logic        unused_port_o;

  kbd_at2xt u_at2xt (
    .ps2_data (ps2_data),
    .xt       (xt)
  );

  assign unused_port_o = ^port_o[7:2];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign load  = !obf && !empty;

  assign rd_data = port_clk && !port_w && (port == KBD_DATA_PORT);
  assign rd_stat = port_clk && !port_w && (port == KBD_STAT_PORT);
  assign wr_stat = port_clk &&  port_w && (port == KBD_STAT_PORT);
  assign flush   = wr_stat && port_o[1];

  // A pop on the same edge frees the slot the push lands in.
  assign push_req = ps2_hit && (ps2_data != AT_BREAK);
  assign push_val = (state == BREAK) ? {1'b1, xt[6:0]} : xt;
  assign push_ok  = push_req && (!full || load);
  assign drop     = push_req && full && !load;

  always_ff @(posedge clock) begin
    if (!reset && !flush && push_ok)
      mem[wptr[AW-1:0]] <= push_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      wptr   <= '0;
      rptr   <= '0;
      latch  <= 8'h00;
      obf    <= 1'b0;
      irq_en <= 1'b1;
      ovf    <= 1'b0;
      port_i <= 8'h00;
    end else begin
      if (rd_data)
        port_i <= latch;
      else if (rd_stat)
        port_i <= stat_byte(irq_en, ovf, obf);

      if (flush) begin
        wptr   <= rptr;
        state  <= IDLE;
        obf    <= 1'b0;
        ovf    <= 1'b0;
        irq_en <= port_o[0];
      end else begin
        if (push_ok)
          wptr <= wptr + 1'b1;

        if (ps2_hit) begin
          if (ps2_data == AT_BREAK)
            state <= BREAK;
          else
            state <= IDLE;
        end

        if (load) begin
          latch <= mem[rptr[AW-1:0]];
          rptr  <= rptr + 1'b1;
          obf   <= 1'b1;
        end else if (rd_data) begin
          obf <= 1'b0;
        end

        // A status read clears ovf even if a drop happens on the same edge.
        if (rd_stat)
          ovf <= 1'b0;
        else if (drop)
          ovf <= 1'b1;

        if (wr_stat)
          irq_en <= port_o[0];
      end
    end
  end

  assign kbd_irq = obf && irq_en;
  assign kbd_ovf = ovf;

endmodule

// File: tb/tb_kbd_ctl.sv
// Scoreboard bench for kbd_ctl: a queue-based reference model predicts port
// reads and per-cycle IRQ/overflow levels; a monitor compares DUT outputs.
module tb_kbd_ctl;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic [7:0]  ps2_data;
  logic        ps2_hit;
  logic        port_clk;
  logic [15:0] port;
  logic        port_w;
  logic [7:0]  port_o;
  logic [7:0]  port_i;
  logic        kbd_irq;
  logic        kbd_ovf;

  kbd_ctl #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_data (ps2_data),
    .ps2_hit  (ps2_hit),
    .port_clk (port_clk),
    .port     (port),
    .port_w   (port_w),
    .port_o   (port_o),
    .port_i   (port_i),
    .kbd_irq  (kbd_irq),
    .kbd_ovf  (kbd_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: latch + queue of waiting bytes.
  logic [7:0] tbl [logic [7:0]];
  logic [7:0] m_q [$];
  logic [7:0] m_latch;
  logic       m_obf, m_ien, m_ovf, m_brk;

  logic [7:0] rd_q  [$];
  logic [1:0] sig_q [$];
  logic [7:0] codes [$];

  function automatic logic [7:0] to_xt(input logic [7:0] b);
    if (tbl.exists(b)) return tbl[b];
    return b;
  endfunction

  task automatic model_step();
    logic rd60, rd64, wr64, ld, drop;
    logic [7:0] v;
    if (reset) begin
      m_q.delete();
      m_latch = 8'h00; m_obf = 1'b0; m_ien = 1'b1; m_ovf = 1'b0; m_brk = 1'b0;
    end else begin
      rd60 = port_clk && !port_w && port == 16'h0060;
      rd64 = port_clk && !port_w && port == 16'h0064;
      wr64 = port_clk &&  port_w && port == 16'h0064;
      if (rd60) rd_q.push_back(m_latch);
      if (rd64) rd_q.push_back({5'b0, m_ien, m_ovf, m_obf});
      if (wr64 && port_o[1]) begin
        m_q.delete();
        m_obf = 1'b0; m_ovf = 1'b0; m_brk = 1'b0; m_ien = port_o[0];
      end else begin
        ld = !m_obf && m_q.size() > 0;
        drop = 1'b0;
        if (ld) m_latch = m_q.pop_front();
        if (ps2_hit) begin
          if (ps2_data == 8'hF0) m_brk = 1'b1;
          else begin
            v = to_xt(ps2_data);
            if (m_brk) v = v | 8'h80;
            m_brk = 1'b0;
            if (m_q.size() < DEPTH) m_q.push_back(v);
            else drop = 1'b1;
          end
        end
        if (ld) m_obf = 1'b1;
        else if (rd60) m_obf = 1'b0;
        if (rd64) m_ovf = 1'b0;
        else if (drop) m_ovf = 1'b1;
        if (wr64) m_ien = port_o[0];
      end
    end
    sig_q.push_back({m_obf && m_ien, m_ovf});
  endtask

  task automatic cyc(input logic rst, input logic hit, input logic [7:0] d,
                     input logic pclk, input logic [15:0] p, input logic pw,
                     input logic [7:0] po);
    reset = rst; ps2_hit = hit; ps2_data = d;
    port_clk = pclk; port = p; port_w = pw; port_o = po;
    model_step();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
  endtask
  task automatic hit(input logic [7:0] b);
    cyc(1'b0, 1'b1, b, 1'b0, 16'h0000, 1'b0, 8'h00);
  endtask
  task automatic rd(input logic [15:0] p);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, p, 1'b0, 8'h00);
  endtask
  task automatic wr(input logic [15:0] p, input logic [7:0] v);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, p, 1'b1, v);
  endtask
  task automatic rst_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
  endtask

  // Monitor: a read at a posedge is compared on the following negedge.
  logic rd_seen = 1'b0;
  always @(posedge clock)
    rd_seen <= !reset && port_clk && !port_w && (port == 16'h0060 || port == 16'h0064);

  always @(negedge clock) begin
    logic [7:0] e;
    logic [1:0] s;
    if (rd_seen) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL port_i_read: got %02h, no expected value queued", port_i);
      end else begin
        e = rd_q.pop_front();
        if (port_i !== e) begin
          errors++;
          $display("FAIL port_i_read t=%0t: got %02h expected %02h", $time, port_i, e);
        end
      end
    end
    if (sig_q.size() > 0) begin
      s = sig_q.pop_front();
      checks += 2;
      if (kbd_irq !== s[1]) begin
        errors++;
        $display("FAIL kbd_irq t=%0t: got %b expected %b", $time, kbd_irq, s[1]);
      end
      if (kbd_ovf !== s[0]) begin
        errors++;
        $display("FAIL kbd_ovf t=%0t: got %b expected %b", $time, kbd_ovf, s[0]);
      end
    end
  end

  initial begin
    tbl[8'h1C] = 8'h1E; tbl[8'h16] = 8'h02; tbl[8'h75] = 8'h48; tbl[8'h76] = 8'h01;
    tbl[8'h5A] = 8'h1C; tbl[8'h29] = 8'h39; tbl[8'h12] = 8'h2A; tbl[8'h14] = 8'h1D;
    tbl[8'h15] = 8'h10; tbl[8'h1D] = 8'h11; tbl[8'h24] = 8'h12; tbl[8'h2D] = 8'h13;
    tbl[8'h66] = 8'h0E; tbl[8'h0D] = 8'h0F; tbl[8'h05] = 8'h3B; tbl[8'h83] = 8'h41;
    tbl[8'h45] = 8'h0B; tbl[8'h4D] = 8'h19; tbl[8'h6B] = 8'h4B; tbl[8'h7C] = 8'h37;
    foreach (tbl[k]) codes.push_back(k);
    codes.push_back(8'hE0); codes.push_back(8'hE1); codes.push_back(8'h00);
    codes.push_back(8'hAA); codes.push_back(8'hF0); codes.push_back(8'hF0);

    rst_cyc(3);
    rd(16'h0064);
    // Make code, then break sequence.
    hit(8'h1C); idle(3); rd(16'h0060); idle(1); rd(16'h0064);
    hit(8'hF0); hit(8'h1C); idle(3); rd(16'h0060); idle(1);
    hit(8'h1C); idle(3); rd(16'h0060); idle(1);
    // Extended prefix passes through; break of keypad 8.
    hit(8'hE0); hit(8'hF0); hit(8'h75); idle(3);
    rd(16'h0060); idle(3); rd(16'h0060); idle(2); rd(16'h0060); idle(1);
    // Overflow: 10 hits with no reads.
    for (int i = 0; i < 10; i++) hit(8'h16);
    idle(2);
    for (int i = 0; i < 10; i++) begin rd(16'h0060); idle(1); end
    rd(16'h0064); rd(16'h0064);
    // IRQ enable, flush.
    hit(8'h1C); idle(3);
    wr(16'h0064, 8'h00); idle(1); rd(16'h0064);
    wr(16'h0064, 8'h01); idle(1); rd(16'h0064);
    hit(8'h29); idle(1); wr(16'h0064, 8'h03); idle(2); rd(16'h0064);
    hit(8'h29); idle(3); wr(16'h0064, 8'h02); idle(2); rd(16'h0064);
    wr(16'h0064, 8'h01); idle(1);
    // Flush coincident with a hit drops the byte.
    cyc(1'b0, 1'b1, 8'h5A, 1'b1, 16'h0064, 1'b1, 8'h03); idle(3); rd(16'h0064);
    // Other ports and a 60h write have no effect.
    hit(8'h76); idle(3); wr(16'h0060, 8'h02); rd(16'h0070); idle(1); rd(16'h0060); idle(1);
    // Reset loses a pending break prefix.
    hit(8'hF0); rst_cyc(1); hit(8'h1C); idle(3); rd(16'h0060); idle(1);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 30)      hit(codes[$urandom_range(0, codes.size() - 1)]);
      else if (r < 45) rd(16'h0060);
      else if (r < 52) rd(16'h0064);
      else if (r < 54) wr(16'h0064, 8'($urandom_range(0, 255)));
      else if (r < 55) wr(16'h0060, 8'($urandom_range(0, 255)));
      else if (r < 56) rd(16'h0061);
      else if (r < 58) cyc(1'b0, 1'b1, codes[$urandom_range(0, codes.size() - 1)],
                           1'b1, 16'h0064, 1'b0, 8'h00);
      else if (i % 700 == 699) rst_cyc(1);
      else idle(1);
    end
    idle(4);
    repeat (2) @(negedge clock);
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL read_queue_drain: %0d expected reads left, required 0", rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
